adrv9001_rx_capture_ctrl: RTL and testbench
===========================================

ADRV9001_RX_CAPTURE_CTRL -- requirements
Module: adrv9001_rx_capture_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the sample-count fields.
REQ-002 SHALL have parameter TO_WIDTH, default 24: width of the trigger-timeout counter.
REQ-003 SHALL have port clk  input  1: single clock, RX divided data clock domain.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: single-cycle arm request.
REQ-006 SHALL have port abort  input  1: cancel the current capture.
REQ-007 SHALL have port trig_mode  input  1: 0 = start capture immediately; 1 = wait for trig.
REQ-008 SHALL have port trig  input  1: external capture trigger, level-sampled.
REQ-009 SHALL have port num_samples  input  CNT_WIDTH: capture length, latched on start.
REQ-010 SHALL have ports s_axis_tdata  input  32 and s_axis_tvalid  input  1: free-running aligned {I,Q} stream with no backpressure.
REQ-011 SHALL have ports m_axis_tdata  output  32, m_axis_tvalid  output  1, m_axis_tready  input  1 and m_axis_tlast  output  1: captured stream.
REQ-012 SHALL have ports busy  output  1, done  output  1 and overflow  output  1 (sticky), plus sample_count  output  CNT_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_TRIG, CAPTURE and DRAIN; busy SHALL be 1 in every state except IDLE.
REQ-014 IDLE: start with num_samples!=0 SHALL go to WAIT_TRIG if trig_mode=1, else to CAPTURE, on the next cycle; it SHALL latch num_samples and clear sample_count and overflow.
REQ-015 A start with num_samples=0 SHALL be ignored: the FSM stays in IDLE and done is not pulsed.
REQ-016 start while busy SHALL be ignored.
REQ-017 WAIT_TRIG: trig=1 in cycle n SHALL move the FSM to CAPTURE in cycle n+1; the sample present in cycle n is not captured.
REQ-018 CAPTURE: a sample is accepted when s_axis_tvalid=1 and the internal 4-entry FIFO is not full (a simultaneous pop frees the entry).
REQ-019 Each accepted sample SHALL increment sample_count.
REQ-020 FIFO full and s_axis_tvalid=1 SHALL drop the sample, set overflow, and leave sample_count unchanged.
REQ-021 After the sample that makes sample_count equal the latched length is accepted, the FSM SHALL move to DRAIN on the next cycle; no further samples are accepted.
REQ-022 Latency: a sample accepted in cycle n into an empty FIFO SHALL appear on m_axis_tdata with m_axis_tvalid=1 in cycle n+1.
REQ-023 Output handshake: data is popped on m_axis_tvalid & m_axis_tready; m_axis_tdata and m_axis_tvalid SHALL hold stable while tvalid=1 and tready=0.
REQ-024 m_axis_tlast SHALL be 1 only with the final sample of the capture (count index = length).
REQ-025 DRAIN: the handshake of the tlast beat SHALL pulse done for exactly one cycle in the following cycle, with the FSM back in IDLE in that same cycle.
REQ-026 abort in any state SHALL force IDLE next cycle, flush the FIFO (m_axis_tvalid=0 next cycle) and suppress done; sample_count and overflow SHALL hold.
REQ-027 abort and start in the same cycle: abort wins and start is ignored.
REQ-028 sample_count SHALL saturate at the latched length and SHALL never wrap.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and flush the FIFO, from any state including mid-capture.
REQ-030 Reset values SHALL be: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, overflow=0, sample_count=0 (and timeout=0 when present).
REQ-031 rst SHALL take priority over abort and start.

Configuration
REQ-032 Macro ADRV9001_RX_CAP_TIMEOUT_EN SHALL control the trigger timeout.
REQ-033 With the macro defined: port timeout_cycles  input  TO_WIDTH and port timeout  output  1 (sticky, cleared on an accepted start) SHALL exist.
REQ-034 With the macro defined: in WAIT_TRIG a counter SHALL count cycles; when it reaches a nonzero timeout_cycles without trig, the FSM SHALL go to IDLE, set timeout and suppress done.
REQ-035 With the macro defined: timeout_cycles=0 SHALL disable the timeout.
REQ-036 Without the macro: both ports SHALL be absent and WAIT_TRIG SHALL wait indefinitely.

Verification
REQ-037 Immediate capture: trig_mode=0, num_samples=8, s_axis_tvalid every cycle, tready=1 -> 8 beats, tlast on the 8th only, done pulses once, sample_count=8.
REQ-038 Backpressure: num_samples=16, tready=0 for 10 cycles -> first 4 samples held in order, then drops; overflow=1, done after the 16th accepted sample drains.
REQ-039 Trigger: trig_mode=1, trig asserted at cycle 20 -> first output equals the sample presented at cycle 21; no output before it.
REQ-040 Abort: abort after 3 of 10 samples -> m_axis_tvalid=0 next cycle, no done, busy=0, sample_count=3.
REQ-041 Reset mid-capture: rst at sample 5 of 10 -> all outputs at reset values next cycle; a subsequent start works normally.
REQ-042 Timeout (macro defined): trig_mode=1, timeout_cycles=100, no trig -> IDLE with timeout=1 after 100 cycles in WAIT_TRIG, no done.

Source files
------------

// File: rtl/adrv9001_rx_capture_ctrl.sv
// ADRV9001 RX capture controller: arm/trigger FSM feeding a 4-deep output FIFO.
// Optional trigger timeout enabled by defining ADRV9001_RX_CAP_TIMEOUT_EN.
module adrv9001_rx_capture_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TO_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 trig_mode,
  input  logic                 trig,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] sample_count
`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
  ,
  input  logic [TO_WIDTH-1:0]  timeout_cycles,
  output logic                 timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic                 r_done;

  logic [31:0]          r_mem [4];
  logic [3:0]           r_mem_last;
  logic [1:0]           r_wr, r_rd;
  logic [2:0]           r_cnt;

  logic w_full, w_pop, w_accept, w_drop, w_last_beat, w_start_ok, w_pop_last;
  logic w_to_expire;

  assign w_full      = (r_cnt == 3'd4);
  assign w_pop       = (r_cnt != 3'd0) && m_axis_tready;
  assign w_start_ok  = (r_state == S_IDLE) && start && !abort && (num_samples != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_accept    = (r_state == S_CAPT) && !abort && s_axis_tvalid &&
                       (!w_full || w_pop) && (r_count != r_len);
  assign w_drop      = (r_state == S_CAPT) && !abort && s_axis_tvalid && w_full && !w_pop;
  assign w_last_beat = (r_count + CNT_ONE) == r_len;
  assign w_pop_last  = w_pop && m_axis_tlast;

`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_ONE = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                r_timeout;
  logic                w_to_en;

  assign w_to_en     = (timeout_cycles != '0);
  assign w_to_expire = (r_state == S_WAIT) && !trig && w_to_en &&
                       ((r_to_cnt + TO_ONE) == timeout_cycles);
  assign timeout     = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != S_WAIT)  r_to_cnt <= '0;
      else if (w_to_en)       r_to_cnt <= r_to_cnt + TO_ONE;
      if (w_start_ok)                   r_timeout <= 1'b0;
      else if (w_to_expire && !abort)   r_timeout <= 1'b1;
    end
  end
`else
  assign w_to_expire = 1'b0;
  // TO_WIDTH only sizes the timeout hardware; keep it referenced in this build.
  if (TO_WIDTH < 1) begin : g_to_width_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_next = trig_mode ? S_WAIT : S_CAPT;
        S_WAIT:  if (trig) w_next = S_CAPT;
                 else if (w_to_expire) w_next = S_IDLE;
        S_CAPT:  if (w_accept && w_last_beat) w_next = S_DRAIN;
        S_DRAIN: if (w_pop_last) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state != S_IDLE);
    done         = r_done;
    overflow     = r_ovf;
    sample_count = r_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_len   <= num_samples;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_accept) r_count <= r_count + CNT_ONE;
      if (w_drop)   r_ovf   <= 1'b1;
      r_done <= (r_state == S_DRAIN) && w_pop_last && !abort;
    end
  end

  // FIFO entries carry a last flag so tlast follows its sample through backpressure.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr]      <= s_axis_tdata;
        r_mem_last[r_wr] <= w_last_beat;
        r_wr             <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign m_axis_tvalid = (r_cnt != 3'd0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd] : 32'd0;
  assign m_axis_tlast  = m_axis_tvalid && r_mem_last[r_rd];

endmodule

// File: tb/tb_adrv9001_rx_capture_ctrl.sv
// Directed bench for adrv9001_rx_capture_ctrl: immediate, backpressure, trigger,
// abort, reset and (with ADRV9001_RX_CAP_TIMEOUT_EN) timeout scenarios.
module tb_adrv9001_rx_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort, trig_mode, trig;
  logic [15:0] num_samples;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy, done, overflow;
  logic [15:0] sample_count;
`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
  logic [23:0] timeout_cycles;
  logic        timeout;
`endif

  always #5 clk = ~clk;

  adrv9001_rx_capture_ctrl #(.CNT_WIDTH(16), .TO_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .trig_mode(trig_mode), .trig(trig), .num_samples(num_samples),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .overflow(overflow), .sample_count(sample_count)
`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
    , .timeout_cycles(timeout_cycles), .timeout(timeout)
`endif
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_done;
  logic [31:0] dstart;
  logic [31:0] q_d[$];
  logic        q_l[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Each cycle window gets a fresh input sample, so every sample is identifiable.
  task automatic step();
    @(posedge clk);
    #1;
    s_axis_tdata = s_axis_tdata + 32'd1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        q_d.push_back(m_axis_tdata);
        q_l.push_back(m_axis_tlast);
      end
      if (done) n_done++;
      step();
    end
  endtask

  task automatic clr();
    q_d.delete();
    q_l.delete();
    n_done = 0;
  endtask

  task automatic do_start(input logic mode, input logic [15:0] len);
    start       = 1'b1;
    trig_mode   = mode;
    num_samples = len;
    dstart      = s_axis_tdata;
    step();
    start       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig = 1'b0;
    num_samples = 16'd0; s_axis_tdata = 32'h1000_0000; s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
    timeout_cycles = 24'd0;
`endif
    step(); step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  m_axis_tdata,       32'd0);
    chk("rst_busy",   32'(busy),          32'd0);
    chk("rst_done",   32'(done),          32'd0);
    chk("rst_ovf",    32'(overflow),      32'd0);
    chk("rst_count",  32'(sample_count),  32'd0);
    rst = 1'b0;
    step();

    // Immediate capture of 8 with tready=1
    clr();
    do_start(1'b0, 16'd8);
    run(20);
    chk("imm_nbeats", 32'(q_d.size()), 32'd8);
    for (int i = 0; i < q_d.size() && i < 8; i++) begin
      chk("imm_data", q_d[i], dstart + 32'd1 + 32'(i));
      chk("imm_last", 32'(q_l[i]), 32'(i == 7));
    end
    chk("imm_done",  32'(n_done),       32'd1);
    chk("imm_count", 32'(sample_count), 32'd8);
    chk("imm_busy",  32'(busy),         32'd0);

    // Backpressure: 10 stalled cycles fill the FIFO, the rest drop
    clr();
    do_start(1'b0, 16'd16);
    m_axis_tready = 1'b0;
    run(9);
    chk("bp_hold_vld",  32'(m_axis_tvalid), 32'd1);
    chk("bp_hold_data", m_axis_tdata,       dstart + 32'd1);
    chk("bp_ovf_early", 32'(overflow),      32'd1);
    run(1);
    m_axis_tready = 1'b1;
    run(40);
    chk("bp_nbeats", 32'(q_d.size()), 32'd16);
    for (int i = 0; i < q_d.size() && i < 16; i++) begin
      chk("bp_data", q_d[i], (i < 4) ? dstart + 32'd1 + 32'(i) : dstart + 32'd7 + 32'(i));
      chk("bp_last", 32'(q_l[i]), 32'(i == 15));
    end
    chk("bp_ovf",   32'(overflow),     32'd1);
    chk("bp_done",  32'(n_done),       32'd1);
    chk("bp_count", 32'(sample_count), 32'd16);

    // Trigger at window 20; a start while waiting must be ignored
    clr();
    do_start(1'b1, 16'd4);
    chk("trg_ovf_clr", 32'(overflow), 32'd0);
    chk("trg_busy",    32'(busy),     32'd1);
    run(9);
    start = 1'b1; trig_mode = 1'b0; num_samples = 16'd2;
    run(1);
    start = 1'b0; trig_mode = 1'b1;
    run(9);
    chk("trg_no_early", 32'(q_d.size()), 32'd0);
    chk("trg_wait",     32'(busy),       32'd1);
    trig = 1'b1;
    run(1);
    trig = 1'b0;
    run(20);
    chk("trg_nbeats", 32'(q_d.size()), 32'd4);
    for (int i = 0; i < q_d.size() && i < 4; i++) begin
      chk("trg_data", q_d[i], dstart + 32'd21 + 32'(i));
      chk("trg_last", 32'(q_l[i]), 32'(i == 3));
    end
    chk("trg_done",  32'(n_done),       32'd1);
    chk("trg_count", 32'(sample_count), 32'd4);

    // Abort after 3 of 10
    clr();
    do_start(1'b0, 16'd10);
    run(3);
    abort = 1'b1;
    run(1);
    abort = 1'b0;
    chk("abt_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abt_busy",   32'(busy),          32'd0);
    chk("abt_count",  32'(sample_count),  32'd3);
    run(10);
    chk("abt_done",   32'(n_done),        32'd0);
    chk("abt_nbeats", 32'(q_d.size()),    32'd3);

    // Abort wins over a simultaneous start; zero-length start ignored
    start = 1'b1; abort = 1'b1; num_samples = 16'd5; trig_mode = 1'b0;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abtst_busy",  32'(busy),         32'd0);
    chk("abtst_count", 32'(sample_count), 32'd3);
    clr();
    do_start(1'b0, 16'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    run(5);
    chk("zero_done", 32'(n_done), 32'd0);

    // Reset mid-capture, then a normal capture
    clr();
    do_start(1'b0, 16'd10);
    run(4);
    rst = 1'b1;
    step();
    chk("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mrst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("mrst_tdata",  m_axis_tdata,       32'd0);
    chk("mrst_busy",   32'(busy),          32'd0);
    chk("mrst_done",   32'(done),          32'd0);
    chk("mrst_count",  32'(sample_count),  32'd0);
    rst = 1'b0;
    clr();
    do_start(1'b0, 16'd3);
    run(15);
    chk("post_nbeats", 32'(q_d.size()), 32'd3);
    for (int i = 0; i < q_d.size() && i < 3; i++) begin
      chk("post_data", q_d[i], dstart + 32'd1 + 32'(i));
      chk("post_last", 32'(q_l[i]), 32'(i == 2));
    end
    chk("post_done",  32'(n_done),       32'd1);
    chk("post_count", 32'(sample_count), 32'd3);

`ifdef ADRV9001_RX_CAP_TIMEOUT_EN
    // 100-cycle trigger timeout with no trig
    timeout_cycles = 24'd100;
    clr();
    do_start(1'b1, 16'd4);
    run(99);
    chk("to_busy99", 32'(busy),    32'd1);
    chk("to_flag99", 32'(timeout), 32'd0);
    run(1);
    chk("to_busy",   32'(busy),    32'd0);
    chk("to_flag",   32'(timeout), 32'd1);
    run(5);
    chk("to_done",   32'(n_done),  32'd0);
    do_start(1'b0, 16'd1);
    chk("to_clr",    32'(timeout), 32'd0);
    run(10);
    timeout_cycles = 24'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
